core_hazard: RTL

CORE_HAZARD -- requirements
Module: core_hazard

---
 rtl/core_hazard_if.sv | 31 +++
 rtl/core_hazard.sv | 113 +++++++++++
 2 files changed

// File: rtl/core_hazard_if.sv
// Decode-to-hazard-unit bundle: issue request fields, writeback retire, branch resolve,
// and the stall/flush/scoreboard view returned to decode.
interface core_hazard_if;
  logic       issue_valid;
  logic       uses_ra;
  logic       uses_rb;
  logic [2:0] ra;
  logic [2:0] rb;
  logic       writeback;
  logic [2:0] rd;
  logic       mul;
  logic       wb_valid;
  logic [2:0] wb_rd;
  logic       branch_taken;
  logic       stall;
  logic       flush;
  logic [7:0] pending;
  logic       mul_busy;

  modport master (
    output issue_valid, uses_ra, uses_rb, ra, rb, writeback, rd, mul,
           wb_valid, wb_rd, branch_taken,
    input  stall, flush, pending, mul_busy
  );

  modport slave (
    input  issue_valid, uses_ra, uses_rb, ra, rb, writeback, rd, mul,
           wb_valid, wb_rd, branch_taken,
    output stall, flush, pending, mul_busy
  );
endinterface

// File: rtl/core_hazard.sv
// Decode hazard unit: RAW/WAW scoreboard, multiplier occupancy, branch flush sequencer.
// stall is combinational in the issue cycle; flush/pending/mul_busy update one edge later.
module core_hazard #(
  parameter int MUL_CYCLES   = 3,
  parameter int FLUSH_CYCLES = 2
) (
  input logic         clk,
  input logic         rst_n,
  core_hazard_if.slave hz
);

  localparam logic [2:0] MUL_LOAD   = 3'(MUL_CYCLES);
  localparam logic [1:0] FLUSH_LOAD = 2'(FLUSH_CYCLES - 1);

  typedef enum logic {IDLE, FLUSH} state_t;

  state_t     state_q, state_d;
  logic [1:0] fcnt_q, fcnt_d;
  logic [2:0] mcnt_q;
  logic [7:0] pend_q, pend_d;
  logic [7:0] set_vec, clr_vec;
  logic       raw, waw, structural;
  logic       accept;
  logic       flush_w, stall_w, busy_w;

  assign busy_w     = (mcnt_q != 3'd0);
  // pend_q[0] is held at 0, so index 0 can never raise a hazard.
  assign raw        = (hz.uses_ra & pend_q[hz.ra]) | (hz.uses_rb & pend_q[hz.rb]);
  assign waw        = hz.writeback & pend_q[hz.rd];
  assign structural = hz.mul & busy_w;
  assign stall_w    = rst_n & hz.issue_valid & ~flush_w & (raw | waw | structural);
  assign accept     = hz.issue_valid & ~stall_w & ~flush_w;

  // Flush sequencer: state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      fcnt_q  <= 2'd0;
    end else begin
      state_q <= state_d;
      fcnt_q  <= fcnt_d;
    end
  end

  // Flush sequencer: next state. A branch seen while flushing restarts the count.
  always_comb begin
    state_d = state_q;
    fcnt_d  = fcnt_q;
    case (state_q)
      IDLE: begin
        if (hz.branch_taken) begin
          state_d = FLUSH;
          fcnt_d  = FLUSH_LOAD;
        end
      end
      FLUSH: begin
        if (hz.branch_taken) begin
          fcnt_d = FLUSH_LOAD;
        end else if (fcnt_q == 2'd0) begin
          state_d = IDLE;
        end else begin
          fcnt_d = fcnt_q - 2'd1;
        end
      end
      default: begin
        state_d = IDLE;
        fcnt_d  = 2'd0;
      end
    endcase
  end

  // Flush sequencer: outputs.
  always_comb begin
    flush_w = (state_q == FLUSH);
  end

  // Set wins over a same-cycle clear of the same register.
  always_comb begin
    set_vec = 8'h00;
    clr_vec = 8'h00;
    if (accept && hz.writeback) begin
      set_vec = 8'b1 << hz.rd;
    end
    if (hz.wb_valid) begin
      clr_vec = 8'b1 << hz.wb_rd;
    end
    pend_d = ((pend_q & ~clr_vec) | set_vec) & 8'hFE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q <= 8'h00;
    end else begin
      pend_q <= pend_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcnt_q <= 3'd0;
    end else if (accept && hz.mul) begin
      mcnt_q <= MUL_LOAD;
    end else if (mcnt_q != 3'd0) begin
      mcnt_q <= mcnt_q - 3'd1;
    end
  end

  assign hz.stall    = stall_w;
  assign hz.flush    = flush_w;
  assign hz.pending  = pend_q;
  assign hz.mul_busy = busy_w;

endmodule
